uart_echo_fifo: RTL

Buffered, parametrised UART echo block for board-level bring-up. Received words are pushed into a FIFO and drained to the transmitter as it becomes free, so back-to-back traffic and a stalled TX path do not lose data until the FIFO fills. It instantiates the existing `uart_rx` and `uart_tx` cores, sits directly under the board top, and drives the LEDs with the last received word.

---
 rtl/uart_echo_fifo.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo: received words queue in a FIFO and drain to the transmitter; LEDs mirror the last word.
// Define UART_ECHO_BREAK_FLUSH_EN to let a received BREAK empty the FIFO in one cycle.

module uart_rx #(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_break,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
);
    localparam int CYC = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CYC + 1);
    localparam int BW  = $clog2(PAYLOAD_BITS + 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    rx_state_t state, state_next;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_idx;
    logic          bit_tick;
    logic          half_tick;

    assign bit_tick  = (cnt == CW'(CYC - 1));
    assign half_tick = (cnt == CW'(CYC / 2 - 1));

    // A low stop bit (framing error or BREAK) parks in RX_WAIT_HIGH so a long
    // low line is not decoded as further frames.
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:      if (!sync[1]) state_next = RX_START;
            RX_START:     if (half_tick) state_next = sync[1] ? RX_IDLE : RX_DATA;
            RX_DATA:      if (bit_tick && bit_idx == BW'(PAYLOAD_BITS - 1)) state_next = RX_STOP;
            RX_STOP:      if (bit_tick) state_next = sync[1] ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (sync[1]) state_next = RX_IDLE;
            default:      state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync          <= 2'b11;
            state         <= RX_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            uart_rx_data  <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
        end else begin
            sync          <= {sync[0], uart_rxd};
            state         <= state_next;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            cnt           <= (state_next != state || bit_tick) ? '0 : cnt + 1'b1;
            if (state == RX_START) bit_idx <= '0;
            if (state == RX_DATA && bit_tick) begin
                uart_rx_data <= {sync[1], uart_rx_data[PAYLOAD_BITS-1:1]};
                bit_idx      <= bit_idx + 1'b1;
            end
            if (state == RX_STOP && bit_tick) begin
                uart_rx_valid <= sync[1];
                uart_rx_break <= !sync[1] && (uart_rx_data == '0);
            end
        end
    end
endmodule

module uart_tx #(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    uart_txd,
    output logic                    uart_tx_busy,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);
    localparam int CYC = CLK_HZ / BIT_RATE;
    localparam int CW  = $clog2(CYC + 1);
    localparam int BW  = $clog2(PAYLOAD_BITS + 2);

    logic [PAYLOAD_BITS:0] sreg;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_idx;

    // Start bit is driven at load; sreg holds data then the stop bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_txd     <= 1'b1;
            uart_tx_busy <= 1'b0;
            sreg         <= '0;
            cnt          <= '0;
            bit_idx      <= '0;
        end else if (!uart_tx_busy) begin
            if (uart_tx_en) begin
                uart_tx_busy <= 1'b1;
                uart_txd     <= 1'b0;
                sreg         <= {1'b1, uart_tx_data};
                cnt          <= '0;
                bit_idx      <= '0;
            end
        end else if (cnt == CW'(CYC - 1)) begin
            cnt <= '0;
            if (bit_idx == BW'(PAYLOAD_BITS + 1)) begin
                uart_tx_busy <= 1'b0;
                uart_txd     <= 1'b1;
            end else begin
                uart_txd <= sreg[0];
                sreg     <= {1'b1, sreg[PAYLOAD_BITS:1]};
                bit_idx  <= bit_idx + 1'b1;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module uart_echo_fifo #(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int LED_W        = 8
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               uart_rxd,
    output logic                               uart_txd,
    input  logic                               tx_hold,
    output logic [LED_W-1:0]                   led,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               overflow,
    output logic [7:0]                         drop_count
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} tx_state_t;
    tx_state_t state, state_next;

    logic                    rx_valid, rx_break, tx_en, tx_busy;
    logic                    push, pop, flush, full;
    logic [PAYLOAD_BITS-1:0] rx_data, tx_data;
    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;

`ifdef UART_ECHO_BREAK_FLUSH_EN
    assign flush = rx_break;
`else
    logic unused_rx_break;
    assign unused_rx_break = rx_break;
    assign flush = 1'b0;
`endif

    assign full    = (fifo_level == LW'(FIFO_DEPTH));
    assign push    = rx_valid && !flush && (!full || pop);
    assign tx_data = mem[rd_ptr];

    uart_rx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PAYLOAD_BITS)) u_rx (
        .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd),
        .uart_rx_valid(rx_valid), .uart_rx_break(rx_break), .uart_rx_data(rx_data)
    );

    uart_tx #(.CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .PAYLOAD_BITS(PAYLOAD_BITS)) u_tx (
        .clk(clk), .resetn(resetn), .uart_txd(uart_txd),
        .uart_tx_busy(tx_busy), .uart_tx_en(tx_en), .uart_tx_data(tx_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // The level guard in LOAD keeps a flush on the IDLE->LOAD edge from sending stale data.
    always_comb begin
        state_next = state;
        tx_en      = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE:      if (fifo_level != '0 && !tx_hold) state_next = LOAD;
            LOAD: begin
                if (!tx_busy && fifo_level != '0) begin
                    tx_en      = 1'b1;
                    pop        = 1'b1;
                    state_next = WAIT_BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT_BUSY: if (tx_busy) state_next = WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            led        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (rx_valid) led <= rx_data[LED_W-1:0];
            if (rx_valid && !flush && !push) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
            end
            if (flush) begin
                rd_ptr     <= wr_ptr;
                fifo_level <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      fifo_level <= fifo_level + 1'b1;
                else if (pop && !push) fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end
endmodule
